clock_sel_sequencer: RTL and testbench

Sequencer for the divided-clock selection network (the 4-bit `sel` that steers the reconvergent clock muxes). It applies a new selection without glitching downstream flops:
- gate the muxed clock off;
- wait for the divider outputs to go quiet;
- switch `sel` and let the muxes settle;
- re-enable the clock for a fixed capture window.

It also has an autonomous scan mode that steps `sel` through all 16 codes for pattern coverage.

---
 rtl/clock_sel_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_clock_sel_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_sel_sequencer.sv
// clock_sel_sequencer: glitch-free sequencer for the 4-bit divided-clock mux select.
// A new code is applied in four steps. First the muxed clock is gated off for QUIET_CYC
// cycles. Then sel is switched. The muxes are given SETTLE_CYC cycles to settle. Finally
// the clock is re-enabled for a WIN_CYC-cycle capture window. A scan mode steps through
// all 16 codes back to back.
//
// Ports:
//   clk_a       sequencer clock (rising edge)
//   rst_n       synchronous active-low reset
//   req_valid   single request valid; accepted when req_valid && req_ready
//   req_sel     requested code, sampled only at acceptance
//   req_ready   high while idle (combinational)
//   scan_start  starts a 16-code scan from idle (req_valid has priority)
//   abort       drops any in-progress sequence back to idle
//   sel         registered mux select
//   clk_en      registered clock-gate enable
//   win_active  high during the capture window
//   busy        high when not idle
//   done        pulse in the cycle after each window
//   scan_done   pulse coincident with the final scan step's done
//   aborted     pulse in the idle cycle following a taken abort
//   scan_idx    code in progress during a scan, else 0
module clock_sel_sequencer #(
  parameter int unsigned QUIET_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned WIN_CYC    = 16
) (
  input  logic       clk_a,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_sel,
  output logic       req_ready,
  input  logic       scan_start,
  input  logic       abort,
  output logic [3:0] sel,
  output logic       clk_en,
  output logic       win_active,
  output logic       busy,
  output logic       done,
  output logic       scan_done,
  output logic       aborted,
  output logic [3:0] scan_idx
);

  localparam logic [7:0] QuietLoad  = 8'(QUIET_CYC - 1);
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] WinLoad    = 8'(WIN_CYC - 1);

  typedef enum logic [2:0] {StIdle, StGate, StSwitch, StSettle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] target_q, target_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] scan_idx_q, scan_idx_d;
  logic       scan_mode_q, scan_mode_d;
  logic       clk_en_q, clk_en_d;
  logic       win_active_q, win_active_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scan_done_q, scan_done_d;
  logic       aborted_q, aborted_d;
  logic       cnt_zero;

  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    sel_d       = sel_q;
    scan_idx_d  = scan_idx_q;
    scan_mode_d = scan_mode_q;
    aborted_d   = 1'b0;

    if (state_q != StIdle && abort) begin
      state_d     = StIdle;
      scan_mode_d = 1'b0;
      scan_idx_d  = 4'h0;
      aborted_d   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            target_d = req_sel;
            // Already running on the requested code: no need to gate and switch.
            if (req_sel == sel_q && clk_en_q) begin
              state_d = StRun;
              cnt_d   = WinLoad;
            end else begin
              state_d = StGate;
              cnt_d   = QuietLoad;
            end
          end else if (scan_start) begin
            scan_mode_d = 1'b1;
            scan_idx_d  = 4'h0;
            target_d    = 4'h0;
            state_d     = StGate;
            cnt_d       = QuietLoad;
          end
        end
        StGate: begin
          if (cnt_zero) begin
            state_d = StSwitch;
            sel_d   = target_q;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StSwitch: begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end
        StSettle: begin
          if (cnt_zero) begin
            state_d = StRun;
            cnt_d   = WinLoad;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StRun: begin
          if (cnt_zero) state_d = StDone;
          else          cnt_d   = cnt_q - 8'd1;
        end
        StDone: begin
          if (scan_mode_q && scan_idx_q != 4'hF) begin
            scan_idx_d = scan_idx_q + 4'd1;
            target_d   = scan_idx_q + 4'd1;
            state_d    = StGate;
            cnt_d      = QuietLoad;
          end else begin
            state_d     = StIdle;
            scan_mode_d = 1'b0;
            scan_idx_d  = 4'h0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered decodes of the next state so they line up with it.
    unique case (state_d)
      StGate, StSwitch, StSettle: clk_en_d = 1'b0;
      StRun:                      clk_en_d = 1'b1;
      StIdle:                     clk_en_d = aborted_d ? 1'b0 : clk_en_q;
      default:                    clk_en_d = clk_en_q;
    endcase
    win_active_d = (state_d == StRun);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
    scan_done_d  = (state_d == StDone) && scan_mode_q && (scan_idx_q == 4'hF);
  end

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      target_q     <= 4'h0;
      sel_q        <= 4'h0;
      scan_idx_q   <= 4'h0;
      scan_mode_q  <= 1'b0;
      clk_en_q     <= 1'b0;
      win_active_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      sel_q        <= sel_d;
      scan_idx_q   <= scan_idx_d;
      scan_mode_q  <= scan_mode_d;
      clk_en_q     <= clk_en_d;
      win_active_q <= win_active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      scan_done_q  <= scan_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign sel        = sel_q;
  assign clk_en     = clk_en_q;
  assign win_active = win_active_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign scan_done  = scan_done_q;
  assign aborted    = aborted_q;
  assign scan_idx   = scan_idx_q;

endmodule

// File: tb/tb_clock_sel_sequencer.sv
// Directed bench for clock_sel_sequencer with default parameters (Q=4, S=4, W=16).
module tb_clock_sel_sequencer;

  logic       clk_a = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_sel = 4'h0;
  logic       scan_start = 1'b0;
  logic       abort = 1'b0;
  logic       req_ready;
  logic [3:0] sel;
  logic       clk_en;
  logic       win_active;
  logic       busy;
  logic       done;
  logic       scan_done;
  logic       aborted;
  logic [3:0] scan_idx;

  always #5 clk_a = ~clk_a;

  clock_sel_sequencer #(
    .QUIET_CYC (4),
    .SETTLE_CYC(4),
    .WIN_CYC   (16)
  ) dut (
    .clk_a     (clk_a),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .scan_start(scan_start),
    .abort     (abort),
    .sel       (sel),
    .clk_en    (clk_en),
    .win_active(win_active),
    .busy      (busy),
    .done      (done),
    .scan_done (scan_done),
    .aborted   (aborted),
    .scan_idx  (scan_idx)
  );

  // One request: inputs plus hand-computed cycle numbers relative to the acceptance edge.
  typedef struct {
    logic [3:0] req;
    logic       scan;       // also raise scan_start in the acceptance cycle
    logic       fast;
    int         abort_cyc;  // 0 = no abort
    int         sel_cyc;
    int         en_first;
    int         en_last;
    int         done_cyc;
    int         ready_cyc;
  } vec_t;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] cur_sel = 4'h0;

  // Packed view: {sel, scan_idx, clk_en, win_active, busy, done, scan_done, aborted, req_ready}
  function automatic logic [14:0] pk(input logic [3:0] s, input logic [3:0] idx, input logic en,
                                     input logic win, input logic bsy, input logic dn,
                                     input logic sdn, input logic abt, input logic rdy);
    return {s, idx, en, win, bsy, dn, sdn, abt, rdy};
  endfunction

  function automatic logic [14:0] act();
    return {sel, scan_idx, clk_en, win_active, busy, done, scan_done, aborted, req_ready};
  endfunction

  task automatic check(input string name, input int c, input logic [14:0] exp);
    n_tests++;
    if (act() !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h want %h (sel,idx,en,win,busy,done,sdone,abt,rdy)",
               name, c, act(), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic run_req(input string name, input vec_t v);
    logic [3:0] es;
    req_valid  = 1'b1;
    req_sel    = v.req;
    scan_start = v.scan;
    tick();
    req_valid  = 1'b0;
    scan_start = 1'b0;
    req_sel    = ~v.req;  // must be ignored after acceptance
    for (int c = 1; c <= v.ready_cyc; c++) begin
      es = (c >= v.sel_cyc) ? v.req : cur_sel;
      if (v.abort_cyc != 0 && c == v.abort_cyc + 1) begin
        check({name, "_abort"}, c, pk(es, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        // abort still high while idle: must be ignored
        tick();
        check({name, "_idle_abort"}, c + 1,
              pk(es, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        abort = 1'b0;
        break;
      end
      check(name, c, pk(es, 4'h0, v.fast ? 1'b1 : (c >= v.en_first),
                        (c >= v.en_first && c <= v.en_last), (c < v.ready_cyc),
                        (c == v.done_cyc), 1'b0, 1'b0, (c >= v.ready_cyc)));
      if (c == v.abort_cyc) abort = 1'b1;
      if (c < v.ready_cyc) tick();
    end
    cur_sel = v.req;
  endtask

  // Full scan with per-cycle checks; optionally stop inside step stop_k at offset stop_o.
  task automatic run_scan(input string name, input int stop_k, input int stop_o);
    logic [3:0] es;
    logic [3:0] last_sel;
    logic       last_en;
    int         k;
    int         o;
    int         dn_cnt;
    bit         stopped;
    dn_cnt     = 0;
    stopped    = 0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    last_sel   = cur_sel;
    last_en    = 1'b1;
    for (int c = 1; c <= 16 * 26; c++) begin
      k  = (c - 1) / 26;
      o  = c - k * 26;
      es = (o >= 5) ? 4'(k) : ((k == 0) ? cur_sel : 4'(k - 1));
      check(name, c, pk(es, 4'(k), (o >= 10), (o >= 10 && o <= 25), 1'b1, (o == 26),
                        (k == 15 && o == 26), 1'b0, 1'b0));
      if (sel !== last_sel) begin
        n_tests++;
        if (clk_en || last_en) begin
          n_fail++;
          $display("FAIL %s_sel_glitch cyc %0d: got en %b/%b want 0/0", name, c, last_en, clk_en);
        end
      end
      if (done) dn_cnt++;
      last_sel = sel;
      last_en  = clk_en;
      if (k == stop_k && o == stop_o) begin
        stopped = 1;
        break;
      end
      tick();
    end
    if (!stopped) begin
      check({name, "_end"}, 16 * 26 + 1,
            pk(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      n_tests++;
      if (dn_cnt != 16) begin
        n_fail++;
        $display("FAIL %s_done_count: got %0d want 16", name, dn_cnt);
      end
      cur_sel = 4'hF;
    end
  endtask

  vec_t tbl[7];
  vec_t post_rst;

  initial begin
    tbl[0] = '{4'hA, 1'b0, 1'b0, 0, 5, 10, 25, 26, 27};  // normal
    tbl[1] = '{4'hA, 1'b0, 1'b1, 0, 1, 1, 16, 17, 18};   // fast path
    tbl[2] = '{4'h5, 1'b0, 1'b0, 0, 5, 10, 25, 26, 27};
    tbl[3] = '{4'h5, 1'b0, 1'b1, 0, 1, 1, 16, 17, 18};
    tbl[4] = '{4'h3, 1'b0, 1'b0, 12, 5, 10, 25, 26, 27}; // abort in RUN
    tbl[5] = '{4'h3, 1'b1, 1'b0, 0, 5, 10, 25, 26, 27};  // beats scan_start; no fast (clk_en=0)
    tbl[6] = '{4'h3, 1'b0, 1'b1, 0, 1, 1, 16, 17, 18};
    post_rst = '{4'h1, 1'b0, 1'b0, 0, 5, 10, 25, 26, 27};

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset", 0, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < 7; i++) begin
      run_req($sformatf("req%0d", i), tbl[i]);
    end

    run_scan("scan", -1, 0);

    // Reset during RUN of scan step 7.
    run_scan("scan_rst", 7, 15);
    rst_n = 1'b0;
    tick();
    check("mid_reset", 0, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n   = 1'b1;
    cur_sel = 4'h0;
    run_req("post_reset", post_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
